// File: rtl/coin_credit_controller.sv
// Coin credit sequencer: qualifies coin strobes, accumulates credit, vends and pays out change.
// Optional AUTO_REFUND_EN adds an idle timeout that refunds held credit after TIMEOUT_CYCLES.
module coin_credit_controller #(
    parameter int PRICE          = 50,
    parameter int CREDIT_W       = 7,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                nickel,
    input  logic                dime,
    input  logic                quarter,
    input  logic                cancel,
    output logic [CREDIT_W-1:0] credit,
    output logic                vend,
    output logic                coin_reject,
    output logic                ret_quarter,
    output logic                ret_dime,
    output logic                ret_nickel,
    output logic                busy
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] VEND   = 2'd1;
    localparam logic [1:0] CHANGE = 2'd2;

    localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W-1:0] C5      = CREDIT_W'(5);
    localparam logic [CREDIT_W-1:0] C10     = CREDIT_W'(10);
    localparam logic [CREDIT_W-1:0] C25     = CREDIT_W'(25);

    if (PRICE <= 0 || PRICE % 5 != 0 || PRICE + 20 >= 2 ** CREDIT_W || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("coin_credit_controller: illegal parameter combination");
    end

    logic [1:0]          state, state_nx;
    logic [CREDIT_W-1:0] credit_nx, coin_value;
    logic                vend_nx, reject_nx, rq_nx, rd_nx, rn_nx;
    logic                coin_event, coin_valid, timeout_hit;

    assign coin_event = nickel | dime | quarter;
    assign coin_valid = (nickel ^ dime ^ quarter) & ~(nickel & dime & quarter);

    always_comb begin
        coin_value = '0;
        if (quarter)     coin_value = C25;
        else if (dime)   coin_value = C10;
        else if (nickel) coin_value = C5;
    end

`ifdef AUTO_REFUND_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] idle_cnt;

    assign timeout_hit = (state == IDLE) && (credit != '0) && (idle_cnt == CNT_W'(TIMEOUT_CYCLES));

    // Counts only quiet IDLE cycles with money held; any activity restarts the wait.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            idle_cnt <= '0;
        else if (state != IDLE || credit == '0 || coin_event || cancel || timeout_hit)
            idle_cnt <= '0;
        else
            idle_cnt <= idle_cnt + 1'b1;
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        // NOTE: every variable gets a default here so no path infers a latch.
        state_nx  = state;
        credit_nx = credit;
        vend_nx   = 1'b0;
        reject_nx = 1'b0;
        rq_nx     = 1'b0;
        rd_nx     = 1'b0;
        rn_nx     = 1'b0;
        case (state)
            IDLE: begin
                if (cancel && credit != '0) begin
                    state_nx  = CHANGE;
                    reject_nx = coin_event;
                end else if (coin_valid) begin
                    credit_nx = credit + coin_value;
                    if (credit_nx >= PRICE_C) state_nx = VEND;
                end else if (coin_event) begin
                    reject_nx = 1'b1;
                end else if (timeout_hit) begin
                    state_nx = CHANGE;
                end
            end
            VEND: begin
                vend_nx   = 1'b1;
                reject_nx = coin_event;
                credit_nx = credit - PRICE_C;
                state_nx  = (credit_nx != '0) ? CHANGE : IDLE;
            end
            CHANGE: begin
                reject_nx = coin_event;
                if (credit >= C25) begin
                    rq_nx     = 1'b1;
                    credit_nx = credit - C25;
                end else if (credit >= C10) begin
                    rd_nx     = 1'b1;
                    credit_nx = credit - C10;
                end else if (credit != '0) begin
                    rn_nx     = 1'b1;
                    credit_nx = credit - C5;
                end
                if (credit_nx == '0) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            credit      <= '0;
            vend        <= 1'b0;
            coin_reject <= 1'b0;
            ret_quarter <= 1'b0;
            ret_dime    <= 1'b0;
            ret_nickel  <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_nx;
            credit      <= credit_nx;
            vend        <= vend_nx;
            coin_reject <= reject_nx;
            ret_quarter <= rq_nx;
            ret_dime    <= rd_nx;
            ret_nickel  <= rn_nx;
            busy        <= (state_nx != IDLE);
        end
    end

endmodule

// File: tb/tb_coin_credit_controller.sv
// Self-checking bench for coin_credit_controller: directed scenarios plus random traffic
// against a greedy-change reference model. Honours AUTO_REFUND_EN (timeout 10 when defined).
module tb_coin_credit_controller;

    localparam int PRICE    = 50;
    localparam int CREDIT_W = 7;
`ifdef AUTO_REFUND_EN
    localparam int TMO = 10;
    localparam bit AUTO = 1'b1;
`else
    localparam int TMO = 1000;
    localparam bit AUTO = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset, nickel, dime, quarter, cancel;
    logic [CREDIT_W-1:0] credit;
    logic vend, coin_reject, ret_quarter, ret_dime, ret_nickel, busy;

    int total = 0;
    int bad   = 0;

    coin_credit_controller #(.PRICE(PRICE), .CREDIT_W(CREDIT_W), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset), .nickel(nickel), .dime(dime), .quarter(quarter), .cancel(cancel),
        .credit(credit), .vend(vend), .coin_reject(coin_reject), .ret_quarter(ret_quarter),
        .ret_dime(ret_dime), .ret_nickel(ret_nickel), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference model: mode plus a queue of change coins computed greedily in one go.
    typedef enum int {M_IDLE, M_VEND, M_CHANGE} mode_t;
    mode_t m_mode;
    int    m_credit, m_idle;
    int    change_q[$];
    int    e_vend, e_rej, e_rq, e_rd, e_rn, e_busy;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = M_IDLE; m_credit = 0; m_idle = 0; change_q.delete();
        e_vend = 0; e_rej = 0; e_rq = 0; e_rd = 0; e_rn = 0; e_busy = 0;
    endtask

    task automatic build_change(input int amount);
        int r = amount;
        change_q.delete();
        while (r >= 25) begin change_q.push_back(25); r -= 25; end
        while (r >= 10) begin change_q.push_back(10); r -= 10; end
        while (r >= 5)  begin change_q.push_back(5);  r -= 5;  end
    endtask

    task automatic model_step(input logic n, input logic d, input logic q, input logic c);
        int nc = int'(n) + int'(d) + int'(q);
        int v  = 5 * int'(n) + 10 * int'(d) + 25 * int'(q);
        e_vend = 0; e_rej = 0; e_rq = 0; e_rd = 0; e_rn = 0;
        case (m_mode)
            M_VEND: begin
                e_vend = 1; e_rej = (nc > 0); m_idle = 0;
                m_credit -= PRICE;
                build_change(m_credit);
                m_mode = (change_q.size() > 0) ? M_CHANGE : M_IDLE;
            end
            M_CHANGE: begin
                int coin = change_q.pop_front();
                e_rej = (nc > 0); m_idle = 0;
                e_rq = (coin == 25); e_rd = (coin == 10); e_rn = (coin == 5);
                m_credit -= coin;
                if (change_q.size() == 0) m_mode = M_IDLE;
            end
            default: begin
                if (c && m_credit > 0) begin
                    e_rej = (nc > 0); m_idle = 0;
                    build_change(m_credit); m_mode = M_CHANGE;
                end else if (nc == 1) begin
                    m_credit += v; m_idle = 0;
                    if (m_credit >= PRICE) m_mode = M_VEND;
                end else if (nc > 1) begin
                    e_rej = 1; m_idle = 0;
                end else if (m_credit == 0) begin
                    m_idle = 0;
                end else if (AUTO && m_idle == TMO) begin
                    m_idle = 0; build_change(m_credit); m_mode = M_CHANGE;
                end else begin
                    m_idle++;
                end
            end
        endcase
        e_busy = (m_mode != M_IDLE);
    endtask

    task automatic compare_all();
        check("credit", 32'(credit), m_credit);
        check("vend", 32'(vend), e_vend);
        check("coin_reject", 32'(coin_reject), e_rej);
        check("ret_quarter", 32'(ret_quarter), e_rq);
        check("ret_dime", 32'(ret_dime), e_rd);
        check("ret_nickel", 32'(ret_nickel), e_rn);
        check("busy", 32'(busy), e_busy);
    endtask

    // Called at a negedge: drive, let the edge happen, step the model, compare at next negedge.
    task automatic cycle(input logic n, input logic d, input logic q, input logic c);
        nickel = n; dime = d; quarter = q; cancel = c;
        @(posedge clk);
        model_step(n, d, q, c);
        @(negedge clk);
        compare_all();
        nickel = 0; dime = 0; quarter = 0; cancel = 0;
    endtask

    task automatic idle_cycles(input int count);
        for (int i = 0; i < count; i++) cycle(0, 0, 0, 0);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        #1;
        model_reset();
        compare_all();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        nickel = 0; dime = 0; quarter = 0; cancel = 0; reset = 0;
        @(negedge clk);
        apply_reset();

        // Exact price with two quarters: vend two cycles after the second strobe, no change.
        cycle(0, 0, 1, 0); check("q1_credit", 32'(credit), 25);
        cycle(0, 0, 1, 0); check("q2_credit", 32'(credit), 50);
        cycle(0, 0, 0, 0); check("exact_vend", 32'(vend), 1);
        check("exact_credit", 32'(credit), 0);
        idle_cycles(2);

        // 60 cents: vend then a single dime.
        cycle(0, 0, 1, 0); cycle(0, 1, 0, 0); cycle(0, 0, 1, 0);
        check("sixty_credit", 32'(credit), 60);
        cycle(0, 0, 0, 0); check("sixty_vend", 32'(vend), 1);
        cycle(0, 0, 0, 0); check("sixty_ret_dime", 32'(ret_dime), 1);
        check("sixty_done", 32'(credit), 0);
        idle_cycles(2);

        // Two strobes together at credit 15 are rejected.
        cycle(1, 0, 0, 0); cycle(0, 1, 0, 0);
        cycle(1, 1, 0, 0); check("multi_reject", 32'(coin_reject), 1);
        check("multi_credit", 32'(credit), 15);
        cycle(0, 0, 0, 1); idle_cycles(3);

        // Cancel at 40 with a coin inserted during payout.
        cycle(0, 0, 1, 0); cycle(0, 1, 0, 0); cycle(1, 0, 0, 0);
        cycle(0, 0, 0, 1); cycle(0, 1, 0, 0);
        check("refund_q", 32'(ret_quarter), 1);
        check("refund_busy_reject", 32'(coin_reject), 1);
        idle_cycles(3);
        check("refund_done", 32'(credit), 0);

        // Cancel and nickel together, then reset in the middle of the refund.
        cycle(0, 0, 1, 0); cycle(0, 1, 0, 0); cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 1); check("cancel_coin_reject", 32'(coin_reject), 1);
        cycle(0, 0, 0, 0); check("cancel_first_q", 32'(ret_quarter), 1);
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        model_reset();
        compare_all();
        check("midreset_credit", 32'(credit), 0);
        @(negedge clk);
        reset = 1'b0;

        // Held credit with no activity.
        cycle(0, 1, 0, 0);
        if (AUTO) begin
            bit seen = 1'b0;
            for (int i = 0; i < TMO + 4 && !seen; i++) begin
                cycle(0, 0, 0, 0);
                if (ret_dime) seen = 1'b1;
            end
            check("timeout_ret_dime", 32'(seen), 1);
        end else begin
            idle_cycles(1000);
            check("hold_credit", 32'(credit), 10);
            cycle(0, 0, 0, 1);
        end
        idle_cycles(3);

        // Random traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            logic n, d, q, c;
            int r = int'($urandom_range(0, 99));
            n = 0; d = 0; q = 0; c = 0;
            if (r < 45) begin
                case ($urandom_range(0, 2))
                    0: n = 1;
                    1: d = 1;
                    default: q = 1;
                endcase
            end else if (r < 50) begin
                n = 1'($urandom); d = 1'($urandom); q = 1'($urandom);
            end
            if ($urandom_range(0, 99) < 6) c = 1;
            if (c && m_mode == M_IDLE && m_credit == 0) begin n = 0; d = 0; q = 0; end
            cycle(n, d, q, c);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/coin_credit_controller.md
Name: coin_credit_controller

Overview:
Sequencer for the vending machine coin path. It takes per-cycle coin strobes, qualifies each one as exactly one coin, and accumulates credit. When credit reaches the price it issues a vend pulse, then pays out change one coin per cycle. It sits between the debounced coin sensors and the dispense/return actuators.

Parameters:
PRICE, 50, item price in cents; nonzero multiple of 5
CREDIT_W, 7, credit register width; must satisfy PRICE+20 < 2**CREDIT_W
TIMEOUT_CYCLES, 1000, idle cycles before auto-refund (used only with AUTO_REFUND_EN)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
nickel  in  1  single-cycle strobe, 5-cent coin detected
dime  in  1  single-cycle strobe, 10-cent coin detected
quarter  in  1  single-cycle strobe, 25-cent coin detected
cancel  in  1  single-cycle strobe, refund request
credit  out  CREDIT_W  current credit in cents
vend  out  1  one-cycle dispense pulse
coin_reject  out  1  one-cycle pulse, inserted coin returned unaccepted
ret_quarter  out  1  one-cycle pulse, return one quarter
ret_dime  out  1  one-cycle pulse, return one dime
ret_nickel  out  1  one-cycle pulse, return one nickel
busy  out  1  high in VEND or CHANGE

Behaviour:
- All outputs are registered. On reset, state=IDLE and every output is 0. Reset takes effect immediately in any state, including mid-change. Pending change is discarded.
- Coin event: any of nickel, dime or quarter is high in a cycle.
- Valid coin: exactly one of the three strobes is high. Two or three high at once is invalid.
- States: IDLE, VEND, CHANGE.
- IDLE, valid coin in cycle N:
  - credit' = credit + value at N+1.
  - If credit' >= PRICE, the state goes to VEND at N+1.
- IDLE, invalid coin: coin_reject=1 at N+1. Credit is unchanged.
- VEND (one cycle):
  - vend=1.
  - credit is reduced by PRICE.
  - Next state is CHANGE if the remainder is > 0, otherwise IDLE.
- CHANGE, one coin per cycle, largest first:
  - credit >= 25: ret_quarter=1, credit -= 25.
  - else credit >= 10: ret_dime=1, credit -= 10.
  - else: ret_nickel=1, credit -= 5.
  - When credit reaches 0, the state goes to IDLE in the cycle after the last return pulse.
- cancel in IDLE with credit > 0: go to CHANGE with no vend. cancel with credit = 0 is ignored.
- cancel in VEND or CHANGE is ignored.
- cancel and a coin in the same IDLE cycle: cancel wins. The coin gets coin_reject=1 and is not credited.
- Any coin event in VEND or CHANGE: coin_reject=1 next cycle, no credit.
- At most one return pulse is high per cycle, and ret_* are never high together with vend.
- Latency:
  - coin to credit update: 1 cycle.
  - coin that reaches price to vend: 2 cycles.
  - vend to first change coin: 1 cycle.
- credit never exceeds PRICE+20 and never goes negative.

Optional Feature:
AUTO_REFUND_EN:
- Defined:
  - A ceil(log2(TIMEOUT_CYCLES+1))-bit idle counter runs in IDLE while credit > 0.
  - It clears on any coin event or cancel, and holds at 0 when credit = 0.
  - When it reaches TIMEOUT_CYCLES, the state goes to CHANGE next cycle, exactly as for cancel.
- Undefined: no counter. Credit is held indefinitely until it reaches the price or cancel is asserted.

Test Plan:
- quarter, quarter on consecutive cycles -> credit 25 then 50. vend=1 2 cycles after the second strobe. No ret_* pulses. credit returns to 0 and the state to IDLE.
- quarter, dime, quarter (60 cents) -> vend once, then exactly one ret_dime on the next cycle, then IDLE with credit 0.
- nickel and dime high in the same cycle with credit 15 -> coin_reject=1 for one cycle, credit stays 15.
- credit 40, cancel -> ret_quarter, ret_dime, ret_nickel on 3 consecutive cycles, vend stays 0. A coin inserted during payout is answered with coin_reject and not credited.
- credit 40, cancel and nickel in the same cycle -> coin_reject=1, refund of 40. Reset asserted mid-refund -> all outputs 0 immediately, credit 0.
- AUTO_REFUND_EN with TIMEOUT_CYCLES=10, single dime then no activity -> ret_dime follows after 10 idle cycles. Without the macro -> credit is still 10 after 1000 cycles.
